// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Mode encoding, default counter width and channel-index sizing.
package clkdiv_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The reserved encoding behaves exactly like STOP.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_STOP : mode_e'(m);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, shadow config
// and single-step sequencing.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = '0,
  parameter logic [1:0]       DEF_MODE = 2'b01
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  input  logic [1:0]       wr_mode,
  input  logic             step_req,
  output logic             clk_out,
  output logic             rise,
  output logic             busy,
  output logic             step_done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] sh_half;
  mode_e            mode;
  mode_e            sh_mode;
  logic             out;
  logic             stepping;
  logic             pending;
  logic             rise_q;
  logic             done_q;

  logic at_end;
  logic running;
  logic apply;
  logic start;

  assign at_end  = (cnt == half);
  assign running = (mode == MODE_RUN) ||
                   ((mode == MODE_STEP) && stepping);
  // Live channels only switch on the edge that would raise the clock.
  assign apply   = pending && !wr_en &&
                   (!running || (!out && at_end));
  assign start   = (mode == MODE_STEP) && !stepping &&
                   !pending && !wr_en && step_req;

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      cnt      <= '0;
      half     <= DEF_HALF;
      sh_half  <= DEF_HALF;
      mode     <= norm_mode(DEF_MODE);
      sh_mode  <= norm_mode(DEF_MODE);
      out      <= 1'b0;
      stepping <= 1'b0;
      pending  <= 1'b0;
      rise_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      done_q <= 1'b0;
      if (wr_en) begin
        sh_half <= wr_half;
        sh_mode <= norm_mode(wr_mode);
        pending <= 1'b1;
      end
      if (apply) begin
        half    <= sh_half;
        mode    <= sh_mode;
        cnt     <= '0;
        pending <= 1'b0;
        out     <= (sh_mode == MODE_RUN);
        rise_q  <= (sh_mode == MODE_RUN);
        if (stepping) begin
          stepping <= 1'b0;
          done_q   <= 1'b1;
        end
      end else if (start) begin
        stepping <= 1'b1;
        out      <= 1'b1;
        rise_q   <= 1'b1;
        cnt      <= '0;
      end else if (running) begin
        if (at_end) begin
          cnt <= '0;
          if ((mode == MODE_STEP) && !out) begin
            stepping <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            out    <= ~out;
            rise_q <= ~out;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
        out <= 1'b0;
      end
    end
  end

  assign clk_out   = out;
  assign rise      = rise_q;
  assign busy      = pending | stepping;
  assign step_done = done_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
// Decodes config writes and replicates one channel per output.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int               NUM_CH   = 2,
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(49999999),
  parameter logic [1:0]       DEF_MODE = 2'b01,
  localparam int              CH_W     = ch_width(NUM_CH)
) (
  input  logic              I_CLK,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  input  logic [1:0]        wr_mode,
  input  logic [NUM_CH-1:0] step_req,
  output logic [NUM_CH-1:0] O_CLK,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] step_done
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no entry and are dropped.
    assign ch_we[i] = wr_en && (wr_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF),
      .DEF_MODE (DEF_MODE)
    ) u_ch (
      .I_CLK     (I_CLK),
      .rst       (rst),
      .wr_en     (ch_we[i]),
      .wr_half   (wr_half),
      .wr_mode   (wr_mode),
      .step_req  (step_req[i]),
      .clk_out   (O_CLK[i]),
      .rise      (rise[i]),
      .busy      (busy[i]),
      .step_done (step_done[i])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: expected rise cycles are queued
// when stimulus is applied and matched against observed rises.
module tb_prog_clock_divider;

  logic        I_CLK = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [31:0] wr_half;
  logic [1:0]  wr_mode;
  logic [2:0]  step_req;
  logic [2:0]  O_CLK;
  logic [2:0]  rise;
  logic [2:0]  busy;
  logic [2:0]  step_done;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp0[$];
  int exp1[$];
  int obs0[$];
  int obs1[$];

  prog_clock_divider #(
    .NUM_CH   (3),
    .CNT_W    (32),
    .DEF_HALF (32'd3),
    .DEF_MODE (2'b01)
  ) dut (
    .I_CLK     (I_CLK),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_half   (wr_half),
    .wr_mode   (wr_mode),
    .step_req  (step_req),
    .O_CLK     (O_CLK),
    .rise      (rise),
    .busy      (busy),
    .step_done (step_done)
  );

  always #5 I_CLK = ~I_CLK;

  always @(posedge I_CLK) cyc <= cyc + 1;

  always @(posedge I_CLK) begin
    #1;
    if (rise[0]) obs0.push_back(cyc);
    if (rise[1]) obs1.push_back(cyc);
  end

  task automatic tick();
    @(negedge I_CLK);
  endtask

  task automatic idle_in();
    wr_en = 1'b0;
    step_req = '0;
  endtask

  task automatic test_reset();
    int r, e, o;
    rst = 1'b1;
    idle_in();
    wr_ch = '0; wr_half = '0; wr_mode = '0;
    repeat (3) tick();
    checks++;
    if (O_CLK !== 3'b000) begin
      failures++; $display("FAIL reset_oclk got %b need 000", O_CLK);
    end
    checks++;
    if (rise !== 3'b000) begin
      failures++; $display("FAIL reset_rise got %b need 000", rise);
    end
    checks++;
    if (busy !== 3'b000) begin
      failures++; $display("FAIL reset_busy got %b need 000", busy);
    end
    checks++;
    if (step_done !== 3'b000) begin
      failures++; $display("FAIL reset_done got %b need 000", step_done);
    end
    rst = 1'b0;
    r = cyc;
    obs0.delete(); obs1.delete();
    for (int k = 4; k <= 20; k += 8) begin
      exp0.push_back(r + k);
      exp1.push_back(r + k);
    end
    while (cyc < r + 22) begin
      tick();
      if (cyc == r + 7) begin
        checks++;
        if (O_CLK[0] !== 1'b1) begin
          failures++; $display("FAIL run_high got %b need 1", O_CLK[0]);
        end
      end
      if (cyc == r + 8) begin
        checks++;
        if (O_CLK[0] !== 1'b0) begin
          failures++; $display("FAIL run_low got %b need 0", O_CLK[0]);
        end
      end
    end
    while (exp0.size() != 0 || obs0.size() != 0) begin
      e = (exp0.size() != 0) ? exp0.pop_front() : -1;
      o = (obs0.size() != 0) ? obs0.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL run_ch0_rise got cyc %0d need %0d", o, e);
      end
    end
    while (exp1.size() != 0 || obs1.size() != 0) begin
      e = (exp1.size() != 0) ? exp1.pop_front() : -1;
      o = (obs1.size() != 0) ? obs1.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL run_ch1_rise got cyc %0d need %0d", o, e);
      end
    end
  endtask

  task automatic test_retime();
    int c, e, o;
    c = cyc;
    obs0.delete(); obs1.delete();
    exp0.push_back(c + 6); exp0.push_back(c + 10); exp0.push_back(c + 14);
    exp1.push_back(c + 6); exp1.push_back(c + 14);
    while (cyc < c + 16) begin
      idle_in();
      if (cyc == c) begin
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd1; wr_mode = 2'b01;
      end
      tick();
      if (cyc == c + 1 || cyc == c + 5) begin
        checks++;
        if (busy[0] !== 1'b1) begin
          failures++; $display("FAIL retime_busy cyc %0d got %b need 1", cyc, busy[0]);
        end
      end
      if (cyc == c + 6) begin
        checks++;
        if (busy[0] !== 1'b0) begin
          failures++; $display("FAIL retime_idle got %b need 0", busy[0]);
        end
      end
    end
    while (exp0.size() != 0 || obs0.size() != 0) begin
      e = (exp0.size() != 0) ? exp0.pop_front() : -1;
      o = (obs0.size() != 0) ? obs0.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL retime_ch0_rise got cyc %0d need %0d", o, e);
      end
    end
    while (exp1.size() != 0 || obs1.size() != 0) begin
      e = (exp1.size() != 0) ? exp1.pop_front() : -1;
      o = (obs1.size() != 0) ? obs1.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL retime_ch1_rise got cyc %0d need %0d", o, e);
      end
    end
  endtask

  task automatic test_step();
    int d, e, o;
    d = cyc;
    obs1.delete();
    exp1.push_back(d + 7);
    while (cyc < d + 20) begin
      idle_in();
      if (cyc == d) begin
        wr_en = 1'b1; wr_ch = 2'd1; wr_half = 32'd2; wr_mode = 2'b10;
      end
      if (cyc == d + 6 || cyc == d + 9) step_req = 3'b010;
      tick();
      if (cyc == d + 2 || cyc == d + 12) begin
        checks++;
        if (busy[1] !== 1'b1) begin
          failures++; $display("FAIL step_busy cyc %0d got %b need 1", cyc, busy[1]);
        end
      end
      if (cyc == d + 6 || cyc == d + 13) begin
        checks++;
        if (busy[1] !== 1'b0) begin
          failures++; $display("FAIL step_idle cyc %0d got %b need 0", cyc, busy[1]);
        end
      end
      if (cyc == d + 9) begin
        checks++;
        if (O_CLK[1] !== 1'b1) begin
          failures++; $display("FAIL step_high got %b need 1", O_CLK[1]);
        end
      end
      if (cyc == d + 10 || cyc == d + 20) begin
        checks++;
        if (O_CLK[1] !== 1'b0) begin
          failures++; $display("FAIL step_low cyc %0d got %b need 0", cyc, O_CLK[1]);
        end
      end
      if (cyc >= d + 12 && cyc <= d + 14) begin
        checks++;
        if (step_done[1] !== (cyc == d + 13)) begin
          failures++;
          $display("FAIL step_done cyc %0d got %b need %b", cyc, step_done[1], cyc == d + 13);
        end
      end
    end
    while (exp1.size() != 0 || obs1.size() != 0) begin
      e = (exp1.size() != 0) ? exp1.pop_front() : -1;
      o = (obs1.size() != 0) ? obs1.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL step_ch1_rise got cyc %0d need %0d", o, e);
      end
    end
  endtask

  task automatic test_last_write();
    int g, e, o, n;
    idle_in();
    n = 0;
    while (rise[0] !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (rise[0] !== 1'b1) begin
      failures++; $display("FAIL lastwr_align got %b need 1", rise[0]);
    end
    g = cyc;
    obs0.delete();
    exp0.push_back(g + 4); exp0.push_back(g + 20);
    while (cyc < g + 22) begin
      idle_in();
      if (cyc == g) begin
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd5; wr_mode = 2'b01;
      end
      if (cyc == g + 1) begin
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd7; wr_mode = 2'b01;
      end
      tick();
      if (cyc == g + 11) begin
        checks++;
        if (O_CLK[0] !== 1'b1) begin
          failures++; $display("FAIL lastwr_high got %b need 1", O_CLK[0]);
        end
      end
      if (cyc == g + 12) begin
        checks++;
        if (O_CLK[0] !== 1'b0) begin
          failures++; $display("FAIL lastwr_low got %b need 0", O_CLK[0]);
        end
      end
    end
    while (exp0.size() != 0 || obs0.size() != 0) begin
      e = (exp0.size() != 0) ? exp0.pop_front() : -1;
      o = (obs0.size() != 0) ? obs0.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL lastwr_ch0_rise got cyc %0d need %0d", o, e);
      end
    end
  endtask

  task automatic test_bad_ch_stop();
    int h, e, o, n;
    idle_in();
    n = 0;
    while (rise[0] !== 1'b1 && n < 40) begin
      tick(); n++;
    end
    checks++;
    if (rise[0] !== 1'b1) begin
      failures++; $display("FAIL stop_align got %b need 1", rise[0]);
    end
    h = cyc;
    obs0.delete();
    exp0.push_back(h + 16);
    while (cyc < h + 40) begin
      idle_in();
      if (cyc == h) begin
        wr_en = 1'b1; wr_ch = 2'd3; wr_half = 32'd0; wr_mode = 2'b00;
      end
      if (cyc == h + 16) begin
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd7; wr_mode = 2'b00;
      end
      tick();
      if (cyc == h + 1) begin
        checks++;
        if (busy !== 3'b000) begin
          failures++; $display("FAIL badch_busy got %b need 000", busy);
        end
      end
      if (cyc == h + 20) begin
        checks++;
        if (busy[0] !== 1'b1) begin
          failures++; $display("FAIL stop_pending got %b need 1", busy[0]);
        end
      end
      if (cyc == h + 32) begin
        checks++;
        if (busy[0] !== 1'b0) begin
          failures++; $display("FAIL stop_applied got %b need 0", busy[0]);
        end
      end
      if (cyc == h + 33 || cyc == h + 40) begin
        checks++;
        if (O_CLK[0] !== 1'b0) begin
          failures++; $display("FAIL stop_hold cyc %0d got %b need 0", cyc, O_CLK[0]);
        end
      end
    end
    while (exp0.size() != 0 || obs0.size() != 0) begin
      e = (exp0.size() != 0) ? exp0.pop_front() : -1;
      o = (obs0.size() != 0) ? obs0.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL stop_ch0_rise got cyc %0d need %0d", o, e);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    int s, e, o;
    s = cyc;
    idle_in();
    step_req = 3'b010;
    wr_en = 1'b1; wr_ch = 2'd0; wr_half = 32'd0; wr_mode = 2'b01;
    tick();
    idle_in();
    rst = 1'b1;
    checks++;
    if (O_CLK[1] !== 1'b1 || busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre got clk=%b busy=%b need 1 1", O_CLK[1], busy[1]);
    end
    tick();
    checks++;
    if (O_CLK !== 3'b000 || rise !== 3'b000) begin
      failures++; $display("FAIL rstmid_out got clk=%b rise=%b need 000", O_CLK, rise);
    end
    checks++;
    if (busy !== 3'b000 || step_done !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_busy got busy=%b done=%b need 000", busy, step_done);
    end
    rst = 1'b0;
    obs0.delete(); obs1.delete();
    exp0.push_back(s + 6); exp0.push_back(s + 14);
    exp1.push_back(s + 6); exp1.push_back(s + 14);
    while (cyc < s + 16) tick();
    while (exp0.size() != 0 || obs0.size() != 0) begin
      e = (exp0.size() != 0) ? exp0.pop_front() : -1;
      o = (obs0.size() != 0) ? obs0.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL rstmid_ch0_rise got cyc %0d need %0d", o, e);
      end
    end
    while (exp1.size() != 0 || obs1.size() != 0) begin
      e = (exp1.size() != 0) ? exp1.pop_front() : -1;
      o = (obs1.size() != 0) ? obs1.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL rstmid_ch1_rise got cyc %0d need %0d", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_retime();
    test_step();
    test_last_write();
    test_bad_ch_stop();
    // ch1 is still an idle STEP channel with H=2 here.
    test_reset_mid_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
